// File: rtl/dw_weight_fetch_sched.sv
// Depthwise-weight fetch scheduler: issues fixed-length AXI read bursts at a constant
// stride for one layer, bounds outstanding bursts, counts returned beats, flags errors.
module dw_weight_fetch_sched #(
  parameter int unsigned AW              = 32,
  parameter int unsigned BURST           = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [CNT_W-1:0] num_bursts,
  input  logic             buf_space_ok,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    araddr,
  output logic             arvalid,
  output logic [7:0]       arlen,
  input  logic             arready,
  input  logic             rvalid,
  input  logic             rlast,
  output logic             rready,
  output logic             wbuf_we
);

  localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
  localparam logic [OW-1:0] MAX_OUT   = OW'(MAX_OUTSTANDING);
  localparam logic [AW-1:0] STRIDE    = AW'(BURST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [OW-1:0]    out_q, out_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             arvalid_q, arvalid_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic busy_w;
  logic beat_acc;
  logic beat_ok;
  logic beat_at_last;
  logic burst_end;
  logic ar_hs;

  assign busy_w       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign beat_acc     = rvalid & busy_w;
  assign beat_ok      = beat_acc & (out_q != '0);
  assign beat_at_last = (beat_q == LAST_BEAT);
  // A burst closes on rlast or on its final beat; both retire one outstanding AR
  // so a missing rlast is flagged without stalling the drain.
  assign burst_end    = beat_ok & (rlast | beat_at_last);
  assign ar_hs        = arvalid_q & arready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    total_d   = total_q;
    issued_d  = issued_q;
    out_d     = out_q;
    beat_d    = beat_q;
    arvalid_d = arvalid_q;
    err_d     = err_q;
    done_d    = (state_q == S_DONE);

    unique case ({ar_hs, burst_end})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase

    if (beat_ok) begin
      beat_d = (rlast | beat_at_last) ? '0 : beat_q + BW'(1);
    end

    if (beat_acc && ((out_q == '0) || (rlast != beat_at_last))) begin
      err_d = 1'b1;
    end

    if (ar_hs) begin
      addr_d   = addr_q + STRIDE;
      issued_d = issued_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          total_d   = num_bursts;
          issued_d  = '0;
          out_d     = '0;
          beat_d    = '0;
          err_d     = 1'b0;
          arvalid_d = 1'b0;
          state_d   = (num_bursts == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ar_hs) begin
          if (issued_d == total_q) begin
            arvalid_d = 1'b0;
            state_d   = S_DRAIN;
          end else begin
            // Re-evaluate with the post-handshake counts to allow back-to-back ARs.
            arvalid_d = (out_d < MAX_OUT) & buf_space_ok;
          end
        end else if (!arvalid_q) begin
          arvalid_d = (out_q < MAX_OUT) & buf_space_ok & (issued_q < total_q);
        end
      end
      S_DRAIN: begin
        if (out_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      total_q   <= '0;
      issued_q  <= '0;
      out_q     <= '0;
      beat_q    <= '0;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      total_q   <= total_d;
      issued_q  <= issued_d;
      out_q     <= out_d;
      beat_q    <= beat_d;
      arvalid_q <= arvalid_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_w;
  assign done    = done_q;
  assign err     = err_q;
  assign araddr  = addr_q;
  assign arvalid = arvalid_q;
  assign arlen   = 8'(BURST - 1);
  assign rready  = busy_w;
  assign wbuf_we = beat_ok;

endmodule

// File: tb/tb_dw_weight_fetch_sched.sv
// Bench for dw_weight_fetch_sched: table of layer configurations served by a randomized
// AXI slave model, plus directed sequences for backpressure, reset, overlap and errors.
module tb_dw_weight_fetch_sched;

  localparam int unsigned AW    = 32;
  localparam int unsigned BURST = 16;
  localparam int unsigned MAXO  = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [CNT_W-1:0] num_bursts = '0;
  logic             buf_space_ok = 1'b0;
  logic             busy, done, err;
  logic [AW-1:0]    araddr;
  logic             arvalid;
  logic [7:0]       arlen;
  logic             arready = 1'b0;
  logic             rvalid = 1'b0;
  logic             rlast = 1'b0;
  logic             rready, wbuf_we;

  int vectors = 0;
  int miscompares = 0;

  dw_weight_fetch_sched #(
    .AW(AW),
    .BURST(BURST),
    .MAX_OUTSTANDING(MAXO),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .num_bursts(num_bursts),
    .buf_space_ok(buf_space_ok),
    .busy(busy),
    .done(done),
    .err(err),
    .araddr(araddr),
    .arvalid(arvalid),
    .arlen(arlen),
    .arready(arready),
    .rvalid(rvalid),
    .rlast(rlast),
    .rready(rready),
    .wbuf_we(wbuf_we)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] base;
    logic [15:0] nb;
    logic [31:0] exp_last;
    int          exp_beats;
    bit          rnd;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    base_addr  = b;
    num_bursts = n;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input int last_at, input logic exp_we);
    for (int i = 0; i < n; i++) begin
      rvalid = 1'b1;
      rlast  = (i == last_at);
      #1;
      chk("beat_we", wbuf_we, exp_we);
      @(negedge clk);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic wait_arvalid(input int bound);
    int i = 0;
    while (!arvalid && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk("arvalid_seen", arvalid, 1);
  endtask

  task automatic wait_done(input int bound);
    int i = 0;
    bit seen = 0;
    while (!seen && i < bound) begin
      if (done) seen = 1;
      else begin
        @(negedge clk);
        i++;
      end
    end
    chk("done_seen", seen, 1);
  endtask

  // Transaction-level AXI slave and reference: bursts return in order, beats only for
  // accepted ARs, addresses follow base + k*BURST modulo 2^32.
  task automatic serve(input logic [31:0] base, input int nb, input logic [31:0] exp_last,
                       input int exp_beats, input bit rnd, input logic exp_err);
    int k = 0, pend = 0, prev_pend = 0, bidx = 0, wb = 0;
    int done_cnt = 0, post = 0, cycles = 0;
    logic prev_arv = 0, prev_ardy = 0, prev_bufok = 0, first = 1;
    logic [31:0] prev_addr = '0, last = '0, exp_a;
    while (cycles < 3000 && post < 3) begin
      if (!first) begin
        if (prev_arv && !prev_ardy) begin
          chk("ar_hold_valid", arvalid, 1);
          chk("ar_hold_addr", araddr, prev_addr);
        end
        if (!prev_arv && arvalid) begin
          chk("ar_rise_bufok", prev_bufok, 1);
          chk("ar_rise_room", prev_pend < MAXO, 1);
        end
      end
      first = 0;
      if (done) begin
        done_cnt++;
        chk("done_busy", busy, 0);
      end
      if (done_cnt > 0) post++;
      if (rnd) begin
        arready      = ($urandom_range(0, 2) != 0);
        buf_space_ok = ($urandom_range(0, 3) != 0);
        rvalid       = (pend > 0) && ($urandom_range(0, 1) != 0);
      end else begin
        arready      = 1'b1;
        buf_space_ok = 1'b1;
        rvalid       = (pend > 0);
      end
      rlast = rvalid && (bidx == BURST - 1);
      #1;
      chk("wbuf_we", wbuf_we, rvalid);
      wb += int'(wbuf_we);
      prev_pend  = pend;
      prev_arv   = arvalid;
      prev_ardy  = arready;
      prev_addr  = araddr;
      prev_bufok = buf_space_ok;
      if (arvalid && arready) begin
        exp_a = base + 32'(k * BURST);
        chk("araddr", araddr, exp_a);
        last = araddr;
        k++;
        pend++;
      end
      if (rvalid) begin
        if (rlast) begin
          pend--;
          bidx = 0;
        end else bidx++;
      end
      chk("outstanding_max", pend <= MAXO, 1);
      @(negedge clk);
      cycles++;
    end
    rvalid  = 1'b0;
    rlast   = 1'b0;
    arready = 1'b0;
    chk("ar_count", k, nb);
    chk("wbuf_we_count", wb, exp_beats);
    chk("last_araddr", last, exp_last);
    chk("done_pulses", done_cnt, 1);
    chk("err_final", err, exp_err);
    chk("busy_final", busy, 0);
  endtask

  initial begin
    int cnt;
    logic [31:0] held;

    tbl[0] = '{32'h0000_1000, 16'd3, 32'h0000_1020, 48,  1'b0};
    tbl[1] = '{32'hFFFF_FFF0, 16'd2, 32'h0000_0000, 32,  1'b1};
    tbl[2] = '{32'h0000_0000, 16'd0, 32'h0000_0000, 0,   1'b1};
    tbl[3] = '{32'h0000_0100, 16'd6, 32'h0000_0150, 96,  1'b1};
    tbl[4] = '{32'h8000_0008, 16'd1, 32'h8000_0008, 16,  1'b0};
    tbl[5] = '{32'h1234_5670, 16'd9, 32'h1234_56F0, 144, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_rready", rready, 0);
    chk("arlen", arlen, 15);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero bursts: done two cycles after start, no AR, never busy.
    do_start(32'h0000_0AB0, 16'd0);
    chk("zero_done_c1", done, 0);
    chk("zero_busy_c1", busy, 0);
    @(negedge clk);
    chk("zero_done_c2", done, 1);
    chk("zero_arvalid", arvalid, 0);
    @(negedge clk);
    chk("zero_done_c3", done, 0);

    for (int v = 0; v < 6; v++) begin
      do_start(tbl[v].base, tbl[v].nb);
      serve(tbl[v].base, int'(tbl[v].nb), tbl[v].exp_last, tbl[v].exp_beats, tbl[v].rnd, 1'b0);
      @(negedge clk);
    end

    // Backpressure with stalled R channel, then hold under buf_space_ok=0, then async reset.
    arready = 1'b1;
    buf_space_ok = 1'b1;
    do_start(32'h0000_2000, 16'd6);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (arvalid && arready) cnt++;
      @(negedge clk);
    end
    chk("bp_ar_count", cnt, 4);
    chk("bp_arvalid_low", arvalid, 0);
    arready = 1'b0;
    send_beats(16, 15, 1'b1);
    wait_arvalid(6);
    chk("bp_5th_addr", araddr, 32'h0000_2040);
    held = araddr;
    buf_space_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", arvalid, 1);
      chk("bp_hold_addr", araddr, held);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_arvalid", arvalid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_araddr", araddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    buf_space_ok = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_arvalid", arvalid, 0);

    // AR handshake coinciding with an rlast beat keeps outstanding unchanged.
    do_start(32'h0000_3000, 16'd2);
    wait_arvalid(10);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("b2b_arvalid", arvalid, 1);
    chk("b2b_araddr", araddr, 32'h0000_3010);
    send_beats(15, -1, 1'b1);
    rvalid = 1'b1;
    rlast = 1'b1;
    arready = 1'b1;
    #1;
    chk("sim_we", wbuf_we, 1);
    chk("sim_arvalid", arvalid, 1);
    @(negedge clk);
    rvalid = 1'b0;
    rlast = 1'b0;
    arready = 1'b0;
    chk("sim_busy_a", busy, 1);
    @(negedge clk);
    chk("sim_busy_b", busy, 1);
    send_beats(16, 15, 1'b1);
    wait_done(10);
    chk("sim_err", err, 0);
    @(negedge clk);

    // Early rlast, sticky err, start while busy, beat with nothing outstanding.
    arready = 1'b1;
    do_start(32'h0000_4000, 16'd1);
    wait_arvalid(10);
    @(negedge clk);
    arready = 1'b0;
    send_beats(10, 9, 1'b1);
    chk("early_rlast_err", err, 1);
    wait_done(10);
    @(negedge clk);
    chk("err_sticky", err, 1);
    do_start(32'h0000_5000, 16'd2);
    chk("err_cleared", err, 0);
    wait_arvalid(10);
    chk("busy_addr", araddr, 32'h0000_5000);
    do_start(32'h0000_6000, 16'd5);
    chk("ign_start_addr", araddr, 32'h0000_5000);
    chk("ign_start_busy", busy, 1);
    rvalid = 1'b1;
    rlast = 1'b0;
    #1;
    chk("orphan_we", wbuf_we, 0);
    @(negedge clk);
    rvalid = 1'b0;
    chk("orphan_err", err, 1);
    serve(32'h0000_5000, 2, 32'h0000_5010, 32, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
